// File: rtl/myproject_dense_acc_26s_16s.sv
// Dense-layer accumulator: sums N_IN signed 26-bit products plus a shifted bias, then emits one 16-bit result.
// Define MYPROJECT_ACC_SAT_EN to saturate the narrowed result instead of wrapping it.
module myproject_dense_acc_26s_16s #(
  parameter int N_IN      = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_SHIFT = 10
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [25:0] prod_data,
  input  logic        prod_vld,
  output logic        prod_rdy,
  input  logic [15:0] bias,
  output logic [15:0] res_data,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic        busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] bias_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] shifted;
  logic [15:0]          narrowed;
  logic                 accept;
  logic                 closing;

  assign prod_ext = {{(ACC_WIDTH-26){prod_data[25]}}, prod_data};
  assign bias_ext = {{(ACC_WIDTH-16){bias[15]}}, bias} << OUT_SHIFT;
  assign sum      = acc + prod_ext + bias_ext;
  assign shifted  = $signed(sum) >>> OUT_SHIFT;
  assign accept   = prod_vld & prod_rdy;
  assign closing  = accept && (cnt == LAST);
  assign busy     = (cnt != '0) || (state == HOLD);

`ifdef MYPROJECT_ACC_SAT_EN
  // Saturate when the bits above the 16-bit field are not a pure sign extension.
  always_comb begin
    narrowed = shifted[15:0];
    if ((shifted[ACC_WIDTH-1:15] != '0) && (shifted[ACC_WIDTH-1:15] != '1)) begin
      narrowed = shifted[ACC_WIDTH-1] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  logic unused_hi;
  assign narrowed  = shifted[15:0];
  assign unused_hi = ^shifted[ACC_WIDTH-1:16];
`endif

  always_comb begin
    state_next = state;
    prod_rdy   = 1'b0;
    res_vld    = 1'b0;
    case (state)
      ACC: begin
        prod_rdy = 1'b1;
        if (closing) state_next = HOLD;
      end
      HOLD: begin
        res_vld = 1'b1;
        if (res_rdy) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // The closing product clears the running sum so the next group starts from zero.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      state <= state_next;
      if (closing) begin
        acc      <= '0;
        cnt      <= '0;
        res_data <= narrowed;
      end else if (accept) begin
        acc <= acc + prod_ext;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc_26s_16s.sv
// Randomized scoreboard bench for the dense accumulator, with an arithmetic reference model.
// Honors MYPROJECT_ACC_SAT_EN for the expected narrowing.
module tb_myproject_dense_acc_26s_16s;

  localparam int    N_IN      = 4;
  localparam int    ACC_WIDTH = 32;
  localparam int    OUT_SHIFT = 10;
  localparam longint SCALE    = longint'(1) << OUT_SHIFT;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [25:0] prod_data = '0;
  logic        prod_vld = 1'b0;
  logic        prod_rdy;
  logic [15:0] bias = '0;
  logic [15:0] res_data;
  logic        res_vld;
  logic        res_rdy = 1'b1;
  logic        busy;

  int     checks = 0;
  int     errors = 0;
  longint exp_q[$];
  longint model_acc = 0;
  int     model_cnt = 0;
  bit     rdy_random = 1'b0;
  bit     started = 1'b0;

  myproject_dense_acc_26s_16s #(
    .N_IN(N_IN), .ACC_WIDTH(ACC_WIDTH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_data(prod_data), .prod_vld(prod_vld), .prod_rdy(prod_rdy),
    .bias(bias), .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint wrapAcc(input longint x);
    longint r;
    r = x % (longint'(1) << ACC_WIDTH);
    if (r < 0) r += longint'(1) << ACC_WIDTH;
    if (r >= (longint'(1) << (ACC_WIDTH - 1))) r -= longint'(1) << ACC_WIDTH;
    return r;
  endfunction

  // Floor division by the output scale, then narrowing to 16 bits.
  function automatic longint expectedResult(input longint s);
    longint q;
    q = s / SCALE;
    if (s < 0 && (s % SCALE) != 0) q -= 1;
`ifdef MYPROJECT_ACC_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`else
    q = q % 65536;
    if (q < 0) q += 65536;
    if (q >= 32768) q -= 65536;
`endif
    return q;
  endfunction

  function automatic bit modelAccept(input int p, input int b);
    if (model_cnt == N_IN - 1) begin
      exp_q.push_back(expectedResult(wrapAcc(model_acc + longint'(p) + longint'(b) * SCALE)));
      model_acc = 0;
      model_cnt = 0;
      return 1'b1;
    end
    model_acc = wrapAcc(model_acc + longint'(p));
    model_cnt++;
    return 1'b0;
  endfunction

  function automatic int randProd();
    logic [25:0] r;
    r = 26'($urandom);
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 8191)) - 4096;
    return int'($signed(r));
  endfunction

  function automatic int randBias();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic applyStimulus(input int p, input int b, input int gap);
    bit got;
    bit closed;
    got = 1'b0;
    repeat (gap) @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    prod_vld  = 1'b1;
    prod_data = p[25:0];
    bias      = b[15:0];
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      if (prod_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checkOutput("accept_timeout", 0, 1);
      prod_vld = 1'b0;
      return;
    end
    closed = modelAccept(p, b);
    @(posedge ap_clk);
    #1;
    prod_vld = 1'b0;
    if (closed) begin
      @(negedge ap_clk);
      checkOutput("latency_res_vld", res_vld, 1);
      checkOutput("closing_prod_rdy", prod_rdy, 0);
    end
  endtask

  task automatic doReset();
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b0;
    prod_vld  = 1'b1;
    prod_data = 26'd1024;
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    prod_vld  = 1'b0;
    exp_q.delete();
    model_acc = 0;
    model_cnt = 0;
    @(negedge ap_clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_res_vld", res_vld, 0);
    checkOutput("reset_prod_rdy", prod_rdy, 1);
    checkOutput("reset_res_data", $signed(res_data), 0);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ap_clk);
      if (exp_q.size() == 0 && res_vld === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (rdy_random) res_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops an expectation on every completed result handshake.
  initial begin
    bit          prev_ok;
    logic        prev_vld;
    logic        prev_rdy;
    logic [15:0] prev_data;
    prev_ok = 1'b0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge ap_clk);
      if (started) begin
        if (ap_rst_n && prev_ok && prev_vld && !prev_rdy) begin
          checkOutput("hold_res_vld", res_vld, 1);
          checkOutput("hold_res_data", $signed(res_data), $signed(prev_data));
        end
        checkOutput("prod_rdy_vs_res_vld", prod_rdy, !res_vld);
        if (ap_rst_n && res_vld === 1'b1 && res_rdy === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got %0d, expected no result", $signed(res_data));
          end else begin
            checkOutput("res_data", $signed(res_data), exp_q.pop_front());
          end
        end
      end
      prev_ok   = ap_rst_n;
      prev_vld  = res_vld;
      prev_rdy  = res_rdy;
      prev_data = res_data;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_res_vld", res_vld, 0);
    checkOutput("init_prod_rdy", prod_rdy, 1);
    checkOutput("init_res_data", $signed(res_data), 0);
    started = 1'b1;

    res_rdy = 1'b1;
    repeat (4) applyStimulus(1024, 0, 0);
    checkOutput("four_1024", $signed(res_data), 4);
    waitDrain();

    repeat (4) applyStimulus(0, 5, 0);
    checkOutput("bias_only", $signed(res_data), 5);
    waitDrain();

    repeat (4) applyStimulus(-1, 0, 0);
    checkOutput("four_minus1", $signed(res_data), -1);
    waitDrain();

    repeat (4) applyStimulus(33554431, 0, 0);
`ifdef MYPROJECT_ACC_SAT_EN
    checkOutput("overflow_narrow", $signed(res_data), 32767);
`else
    checkOutput("overflow_narrow", $signed(res_data), -1);
`endif
    waitDrain();

    // Backpressure: result held while upstream keeps offering data.
    res_rdy = 1'b0;
    repeat (4) applyStimulus(1024, 0, 0);
    prod_vld  = 1'b1;
    prod_data = 26'd2048;
    repeat (3) begin
      @(negedge ap_clk);
      checkOutput("backpressure_prod_rdy", prod_rdy, 0);
      checkOutput("backpressure_res_data", $signed(res_data), 4);
    end
    @(posedge ap_clk);
    #1;
    prod_vld = 1'b0;
    res_rdy  = 1'b1;
    @(negedge ap_clk);
    checkOutput("release_cycle_prod_rdy", prod_rdy, 0);
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    checkOutput("release_next_prod_rdy", prod_rdy, 1);
    waitDrain();

    repeat (2) applyStimulus(1024, 0, 0);
    @(negedge ap_clk);
    checkOutput("partial_busy", busy, 1);
    doReset();
    repeat (4) applyStimulus(1024, 0, 0);
    checkOutput("after_reset_sum", $signed(res_data), 4);
    waitDrain();

    res_rdy = 1'b0;
    repeat (4) applyStimulus(3072, 0, 0);
    doReset();
    res_rdy = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      checkOutput("hold_reset_res_vld", res_vld, 0);
    end

    applyStimulus(2048, -1, 0);
    applyStimulus(-1024, -1, 0);
    applyStimulus(3072, -1, 0);
    applyStimulus(0, -1, 0);
    checkOutput("toggled_vld_sum", $signed(res_data), 3);
    waitDrain();

    rdy_random = 1'b1;
    for (int g = 0; g < 60; g++) begin
      for (int k = 0; k < N_IN; k++) begin
        applyStimulus(randProd(), randBias(), int'($urandom_range(0, 2)));
      end
    end
    waitDrain();
    rdy_random = 1'b0;
    res_rdy = 1'b1;
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/myproject_dense_acc_26s_16s.md
MYPROJECT_DENSE_ACC_26S_16S -- requirements
Module: myproject_dense_acc_26s_16s

Interface
REQ-001 Parameter N_IN, default 16: number of products summed per output (>=1).
REQ-002 Parameter ACC_WIDTH, default 32: accumulator width (>=27).
REQ-003 Parameter OUT_SHIFT, default 10: fractional bits removed from product format to output format.
REQ-004 ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 ap_rst_n  in  1  reset; synchronous, active-low.
REQ-006 prod_data  in  26  signed product from the 16s x 10s multiplier stage.
REQ-007 prod_vld  in  1  prod_data valid.
REQ-008 prod_rdy  out  1  block accepts prod_data this cycle.
REQ-009 bias  in  16  signed bias, output format; sampled only on the closing product.
REQ-010 res_data  out  16  signed accumulated result.
REQ-011 res_vld  out  1  res_data valid.
REQ-012 res_rdy  in  1  downstream accepts res_data.
REQ-013 busy  out  1  high when a partial sum or an unaccepted result is held.

Function
REQ-014 States: ACC (prod_rdy=1, res_vld=0) and HOLD (prod_rdy=0, res_vld=1).
REQ-015 Accept = prod_vld & prod_rdy; each accept adds sign-extended prod_data to acc, wrapping modulo 2^ACC_WIDTH; count cnt increments.
REQ-016 Accept with cnt==N_IN-1 (closing product): compute sum = acc + prod_data + (sign-extended bias << OUT_SHIFT), load res_data, clear acc and cnt to 0, go to HOLD next cycle.
REQ-017 Latency: res_vld rises the cycle after the closing product's accept edge.
REQ-018 res_data = arithmetic right shift of sum by OUT_SHIFT (truncation toward minus infinity), then narrowed to 16 bits per REQ-027.
REQ-019 In HOLD, res_data and res_vld hold stable until res_vld & res_rdy; on that edge go to ACC; prod_rdy rises the following cycle (no same-cycle pass-through).
REQ-020 prod_vld while in HOLD is ignored; upstream holds data until prod_rdy.
REQ-021 N_IN=1: every accept is a closing product.
REQ-022 busy = (cnt!=0) | (state==HOLD).
REQ-023 bias changes while cnt!=0 have no effect unless coincident with the closing product.

Reset
REQ-024 ap_rst_n low at a clock edge: state=ACC, acc=0, cnt=0, res_data=0, res_vld=0, prod_rdy=1 after the edge, busy=0.
REQ-025 Reset mid-accumulation or in HOLD discards partial sum and pending result; no res_vld pulse produced.
REQ-026 Reset dominates any simultaneous accept or result handshake.

Configuration
REQ-027 Macro MYPROJECT_ACC_SAT_EN defined: shifted sum saturates to [-32768, 32767]; undefined: low 16 bits kept (two's-complement wrap).
REQ-028 Macro setting affects only REQ-018 narrowing; timing, handshakes and states identical in both builds.

Verification (N_IN=4, ACC_WIDTH=32, OUT_SHIFT=10)
REQ-029 Four products of 1024, bias 0, res_rdy=1 -> res_data=4, res_vld high one cycle after 4th accept, prod_rdy low that cycle.
REQ-030 Four products of 0, bias 5 -> res_data=5; four products of -1, bias 0 -> res_data=-1.
REQ-031 Four products of 33554431, bias 0 -> res_data=32767 with MYPROJECT_ACC_SAT_EN, res_data=-1 without.
REQ-032 After result, hold res_rdy=0 for 3 cycles with prod_vld=1 -> res_vld and res_data stable, prod_rdy=0, no product consumed; res_rdy=1 -> prod_rdy=1 next cycle.
REQ-033 Accept 2 products of 1024, pulse ap_rst_n low one cycle, then four products of 1024 -> single result res_data=4; busy=0 right after reset.
REQ-034 prod_vld toggled 1/0 every cycle with products 2048,-1024,3072,0 and bias -1 -> res_data=3.
